crc_stream_arbiter: RTL and testbench
=====================================

CRC_STREAM_ARBITER -- requirements
Module: crc_stream_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 256: tdata width per port.
REQ-003 SHALL have parameter KEEP_WIDTH, default 32: tkeep width, equal to DATA_WIDTH/8.
REQ-004 SHALL have parameter CRC_WIDTH, default 32: CRC result width (8, 16 or 32).
REQ-005 SHALL have parameter TAG_DEPTH, default 4: outstanding-packet tag FIFO depth, power of 2.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have port s_axi_stream_tvalid, input, NUM_REQ: per-requester beat valid.
REQ-009 SHALL have port s_axi_stream_tready, output, NUM_REQ: per-requester beat ready.
REQ-010 SHALL have port s_axi_stream_tlast, input, NUM_REQ: per-requester last beat.
REQ-011 SHALL have port s_axi_stream_tuser, input, NUM_REQ: per-requester user bit.
REQ-012 SHALL have port s_axi_stream_tdata, input, NUM_REQ*DATA_WIDTH: requester i in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port s_axi_stream_tkeep, input, NUM_REQ*KEEP_WIDTH: requester i in slice [i*KEEP_WIDTH +: KEEP_WIDTH].
REQ-014 SHALL have port m_axi_stream_tvalid, output, 1: beat valid to the CRC engine.
REQ-015 SHALL have port m_axi_stream_tready, input, 1: CRC engine ready.
REQ-016 SHALL have port m_axi_stream_tlast, output, 1: last beat to the engine.
REQ-017 SHALL have port m_axi_stream_tuser, output, 1: user bit to the engine.
REQ-018 SHALL have port m_axi_stream_tdata, output, DATA_WIDTH: data to the engine.
REQ-019 SHALL have port m_axi_stream_tkeep, output, KEEP_WIDTH: byte keep to the engine.
REQ-020 SHALL have port s_crc_stream_valid, input, 1: engine CRC result valid.
REQ-021 SHALL have port s_crc_stream_ready, output, 1: ready for the engine CRC result.
REQ-022 SHALL have port s_crc_stream_data, input, CRC_WIDTH: engine CRC result.
REQ-023 SHALL have port m_crc_stream_valid, output, NUM_REQ: per-requester result valid.
REQ-024 SHALL have port m_crc_stream_ready, input, NUM_REQ: per-requester result ready.
REQ-025 SHALL have port m_crc_stream_data, output, CRC_WIDTH: result data, broadcast to all requesters.
REQ-026 SHALL have port grant_id, output, clog2(NUM_REQ): current or most recent grantee.
REQ-027 SHALL have port orphan_err, output, 1: sticky flag, set when the engine presents a result while the tag FIFO is empty.

Function
REQ-028 SHALL arbitrate per packet using an FSM with states IDLE and BUSY.
REQ-029 In IDLE, SHALL grant the first requester with tvalid=1, searching round-robin from rr_ptr, only if the tag count < TAG_DEPTH; it then enters BUSY on the next edge.
REQ-030 On grant: grant_id := winner, winner pushed to the tag FIFO, rr_ptr := (winner+1) mod NUM_REQ.
REQ-031 In IDLE, all s_axi_stream_tready=0 and m_axi_stream_tvalid=0, giving exactly one bubble cycle per packet.
REQ-032 In BUSY, the grantee's tvalid/tlast/tuser/tdata/tkeep SHALL pass combinationally to m_axi_stream_*; tready[grant_id]=m_axi_stream_tready, all other tready=0.
REQ-033 In BUSY, a handshake with tlast=1 SHALL return the FSM to IDLE on that edge; other requesters never interleave mid-packet.
REQ-034 Result routing: when the tag FIFO is non-empty with head h, m_crc_stream_valid[h]=s_crc_stream_valid and s_crc_stream_ready=m_crc_stream_ready[h]; all other m_crc_stream_valid=0.
REQ-035 A result handshake SHALL pop the tag FIFO; a push and pop in the same cycle leave the count unchanged.
REQ-036 Full FIFO: no grant until the count drops; a pop in the same cycle does not enable a grant.
REQ-037 Empty FIFO with s_crc_stream_valid=1: s_crc_stream_ready=0 and orphan_err set until reset.
REQ-038 Results are delivered in grant order, assuming an in-order engine.

Reset
REQ-039 On reset_n=0, asynchronously: FSM=IDLE, rr_ptr=0, grant_id=0, tag FIFO empty, orphan_err=0, all tready/valid outputs 0; a packet in flight is abandoned, and the engine shares the same reset.

Verification
REQ-040 Reqs 0 and 2 both valid from reset, each sending a 3-beat packet -> req0 is granted first, then req2 after a 1-cycle bubble; CRCs return to req0 then req2.
REQ-041 All 4 requesters continuously valid -> grants follow 0,1,2,3,0; no mid-packet switch.
REQ-042 m_axi_stream_tready toggles 1010 mid-packet -> beats are not lost or duplicated and the grantee's tready mirrors it.
REQ-043 5 single-beat packets sent with results stalled -> 4 grants, the 5th waits until the first result is popped.
REQ-044 Engine valid with the FIFO empty -> orphan_err=1, s_crc_stream_ready=0.
REQ-045 reset_n dropped mid-packet -> all outputs 0 immediately; the next packet after release is granted from req0 search.

Source files
------------

// File: rtl/crc_stream_arbiter.sv
// Packet-level round-robin arbiter that funnels NUM_REQ AXI-stream requesters into one CRC
// engine and routes each CRC result back to its requester through an in-order tag FIFO.
module crc_stream_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = 32,
    parameter int CRC_WIDTH  = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,

    input  logic [NUM_REQ-1:0]               s_axi_stream_tvalid,
    output logic [NUM_REQ-1:0]               s_axi_stream_tready,
    input  logic [NUM_REQ-1:0]               s_axi_stream_tlast,
    input  logic [NUM_REQ-1:0]               s_axi_stream_tuser,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_axi_stream_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]    s_axi_stream_tkeep,

    output logic                             m_axi_stream_tvalid,
    input  logic                             m_axi_stream_tready,
    output logic                             m_axi_stream_tlast,
    output logic                             m_axi_stream_tuser,
    output logic [DATA_WIDTH-1:0]            m_axi_stream_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axi_stream_tkeep,

    input  logic                             s_crc_stream_valid,
    output logic                             s_crc_stream_ready,
    input  logic [CRC_WIDTH-1:0]             s_crc_stream_data,

    output logic [NUM_REQ-1:0]               m_crc_stream_valid,
    input  logic [NUM_REQ-1:0]               m_crc_stream_ready,
    output logic [CRC_WIDTH-1:0]             m_crc_stream_data,

    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             orphan_err
);

    // state | meaning
    // IDLE  | no packet owns the engine; one bubble cycle while the next grantee is picked
    // BUSY  | grant_id owns the engine until its tlast beat is accepted

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              grant;
    logic              beat_done;

    logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tag_count;
    logic [ID_W-1:0]   tag_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
    logic [KEEP_WIDTH-1:0] req_keep [NUM_REQ];

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(TAG_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = s_axi_stream_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            req_keep[i] = s_axi_stream_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        end
    end

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_index(rr_ptr, k);
            if (!found && s_axi_stream_tvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign fifo_empty = (tag_count == '0);
    assign fifo_full  = (tag_count == CNT_W'(TAG_DEPTH));
    assign tag_head   = tag_mem[rd_ptr];

    // Uses the registered count, so a pop in the same cycle cannot open a slot early.
    assign grant = (state == IDLE) && found && !fifo_full;
    assign push  = grant;

    always_comb begin
        state_next          = state;
        s_axi_stream_tready = '0;
        m_axi_stream_tvalid = 1'b0;
        m_axi_stream_tlast  = 1'b0;
        m_axi_stream_tuser  = 1'b0;
        m_axi_stream_tdata  = req_data[grant_id];
        m_axi_stream_tkeep  = req_keep[grant_id];
        beat_done           = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                m_axi_stream_tvalid           = s_axi_stream_tvalid[grant_id];
                m_axi_stream_tlast            = s_axi_stream_tlast[grant_id];
                m_axi_stream_tuser            = s_axi_stream_tuser[grant_id];
                s_axi_stream_tready[grant_id] = m_axi_stream_tready;
                beat_done = s_axi_stream_tvalid[grant_id] && m_axi_stream_tready;
                if (beat_done && s_axi_stream_tlast[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m_crc_stream_valid = '0;
        s_crc_stream_ready = 1'b0;
        m_crc_stream_data  = s_crc_stream_data;
        if (!fifo_empty) begin
            m_crc_stream_valid[tag_head] = s_crc_stream_valid;
            s_crc_stream_ready           = m_crc_stream_ready[tag_head];
        end
    end

    assign pop = s_crc_stream_valid && s_crc_stream_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                grant_id <= winner;
                rr_ptr   <= rr_index(winner, 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_count  <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                tag_count <= tag_count + 1'b1;
            end else if (pop && !push) begin
                tag_count <= tag_count - 1'b1;
            end
            if (s_crc_stream_valid && fifo_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

endmodule

// File: tb/tb_crc_stream_arbiter.sv
// Directed bench for crc_stream_arbiter: a per-cycle vector table for the basic
// grant/route flow, plus hand sequences for rotation, stalls, FIFO full and reset.
module tb_crc_stream_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 32;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
    logic [DW-1:0]    req_data [NR];
    logic [KW-1:0]    req_keep [NR];
    logic [NR*DW-1:0] s_tdata;
    logic [NR*KW-1:0] s_tkeep;
    logic             m_tvalid, m_tready, m_tlast, m_tuser;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             s_crc_valid, s_crc_ready;
    logic [CW-1:0]    s_crc_data;
    logic [NR-1:0]    m_crc_valid, m_crc_ready;
    logic [CW-1:0]    m_crc_data;
    logic [1:0]       grant_id;
    logic             orphan_err;

    always_comb begin
        s_tdata = '0;
        s_tkeep = '0;
        for (int i = 0; i < NR; i++) begin
            s_tdata[i*DW +: DW] = req_data[i];
            s_tkeep[i*KW +: KW] = req_keep[i];
        end
    end

    crc_stream_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CRC_WIDTH(CW), .TAG_DEPTH(TD)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .s_axi_stream_tvalid (s_tvalid),
        .s_axi_stream_tready (s_tready),
        .s_axi_stream_tlast  (s_tlast),
        .s_axi_stream_tuser  (s_tuser),
        .s_axi_stream_tdata  (s_tdata),
        .s_axi_stream_tkeep  (s_tkeep),
        .m_axi_stream_tvalid (m_tvalid),
        .m_axi_stream_tready (m_tready),
        .m_axi_stream_tlast  (m_tlast),
        .m_axi_stream_tuser  (m_tuser),
        .m_axi_stream_tdata  (m_tdata),
        .m_axi_stream_tkeep  (m_tkeep),
        .s_crc_stream_valid  (s_crc_valid),
        .s_crc_stream_ready  (s_crc_ready),
        .s_crc_stream_data   (s_crc_data),
        .m_crc_stream_valid  (m_crc_valid),
        .m_crc_stream_ready  (m_crc_ready),
        .m_crc_stream_data   (m_crc_data),
        .grant_id            (grant_id),
        .orphan_err          (orphan_err)
    );

    typedef struct {
        logic [3:0] tvalid;
        logic [3:0] tlast;
        logic       m_tready;
        logic       crc_valid;
        logic [3:0] crc_ready;
        logic [3:0] e_tready;
        logic       e_mvalid;
        logic       e_mlast;
        logic [1:0] e_gid;
        logic [3:0] e_crc_valid;
        logic       e_crc_ready;
        logic       e_orphan;
    } vec_t;

    vec_t tbl [13];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        s_tvalid    = '0;
        s_tlast     = '0;
        s_tuser     = '0;
        m_tready    = 1'b0;
        s_crc_valid = 1'b0;
        s_crc_data  = '0;
        m_crc_ready = '0;
        for (int i = 0; i < NR; i++) begin
            req_data[i] = '0;
            req_keep[i] = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_gid [$];
        int beats [NR];
        int hs_cnt;
        int rx_cnt;
        int sent;
        logic hs;
        int exp_order [10];

        //           tvalid   tlast    mrdy  crcv  crcrdy | e_trdy  mv    ml    gid   e_crcv  e_crdy orph
        tbl[0]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b0101, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'b0101, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1};

        // Two 3-beat packets from req0 and req2, their results, then an orphan result.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_data[i] = 32'hA0A0_0000 + 32'(i);
            req_keep[i] = 4'(i + 1);
        end
        s_tuser = 4'b1010;
        for (int r = 0; r < 13; r++) begin
            s_tvalid    = tbl[r].tvalid;
            s_tlast     = tbl[r].tlast;
            m_tready    = tbl[r].m_tready;
            s_crc_valid = tbl[r].crc_valid;
            m_crc_ready = tbl[r].crc_ready;
            s_crc_data  = 32'hC0DE_0000 | 32'(r);
            @(negedge clk);
            check($sformatf("row%0d tready", r), 64'(s_tready), 64'(tbl[r].e_tready));
            check($sformatf("row%0d m_tvalid", r), 64'(m_tvalid), 64'(tbl[r].e_mvalid));
            check($sformatf("row%0d grant_id", r), 64'(grant_id), 64'(tbl[r].e_gid));
            check($sformatf("row%0d m_crc_valid", r), 64'(m_crc_valid), 64'(tbl[r].e_crc_valid));
            check($sformatf("row%0d s_crc_ready", r), 64'(s_crc_ready), 64'(tbl[r].e_crc_ready));
            check($sformatf("row%0d orphan_err", r), 64'(orphan_err), 64'(tbl[r].e_orphan));
            if (tbl[r].e_mvalid) begin
                check($sformatf("row%0d m_tlast", r), 64'(m_tlast), 64'(tbl[r].e_mlast));
                check($sformatf("row%0d m_tdata", r), 64'(m_tdata),
                      64'(32'hA0A0_0000 + 32'(tbl[r].e_gid)));
                check($sformatf("row%0d m_tkeep", r), 64'(m_tkeep), 64'(4'(tbl[r].e_gid) + 4'd1));
                check($sformatf("row%0d m_tuser", r), 64'(m_tuser), 64'(tbl[r].e_gid[0]));
            end
            if (tbl[r].crc_valid) begin
                check($sformatf("row%0d m_crc_data", r), 64'(m_crc_data), 64'(32'hC0DE_0000 | 32'(r)));
            end
            @(posedge clk);
            #1;
        end

        // All four requesters continuously valid with 2-beat packets: 0,1,2,3,0 rotation.
        do_reset();
        exp_order = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        s_tvalid    = 4'b1111;
        m_tready    = 1'b1;
        s_crc_valid = 1'b1;
        m_crc_ready = 4'b1111;
        for (int i = 0; i < NR; i++) beats[i] = 0;
        hs_gid.delete();
        for (int c = 0; c < 60 && hs_gid.size() < 10; c++) begin
            for (int i = 0; i < NR; i++) s_tlast[i] = (beats[i] == 1);
            @(negedge clk);
            hs = m_tvalid && m_tready;
            if (hs) begin
                hs_gid.push_back(int'(grant_id));
                check("rotate tready onehot", 64'(s_tready), 64'(4'b0001 << grant_id));
            end
            @(posedge clk);
            #1;
            if (hs) beats[hs_gid[hs_gid.size()-1]] = 1 - beats[hs_gid[hs_gid.size()-1]];
        end
        check("rotate beat count", 64'(hs_gid.size()), 64'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < hs_gid.size()) check($sformatf("rotate beat%0d grant", k), 64'(hs_gid[k]), 64'(exp_order[k]));
        end

        // req1 sends 4 beats while engine ready toggles 1010.
        do_reset();
        rx_cnt = 0;
        sent   = 0;
        s_crc_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            m_tready    = ~c[0];
            s_tvalid[1] = (sent < 4);
            s_tlast[1]  = (sent == 3);
            req_data[1] = 32'h100 + 32'(sent);
            @(negedge clk);
            if (m_tvalid) begin
                check("stall tready mirror", 64'(s_tready), 64'({2'b00, m_tready, 1'b0}));
            end
            hs = m_tvalid && m_tready;
            if (hs) begin
                check("stall beat data", 64'(m_tdata), 64'(32'h100 + 32'(rx_cnt)));
                rx_cnt++;
            end
            @(posedge clk);
            #1;
            if (hs) sent++;
        end
        check("stall beats received", 64'(rx_cnt), 64'd4);

        // Five single-beat packets with results stalled: tag FIFO caps grants at 4.
        do_reset();
        hs_cnt      = 0;
        s_tvalid[3] = 1'b1;
        s_tlast[3]  = 1'b1;
        m_tready    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_tvalid && m_tready) hs_cnt++;
            @(posedge clk);
            #1;
        end
        check("full grants before pop", 64'(hs_cnt), 64'd4);
        s_crc_valid = 1'b1;
        m_crc_ready = 4'b1000;
        @(negedge clk);
        check("full pop route", 64'(m_crc_valid), 64'(4'b1000));
        check("full pop ready", 64'(s_crc_ready), 64'd1);
        @(posedge clk);
        #1;
        s_crc_valid = 1'b0;
        m_crc_ready = '0;
        @(negedge clk);
        check("full no grant on pop edge", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (m_tvalid && m_tready) hs_cnt++;
            @(posedge clk);
            #1;
        end
        check("full grants after pop", 64'(hs_cnt), 64'd5);

        // Reset asserted mid-packet, then search restarts from req0.
        do_reset();
        s_tvalid[2] = 1'b1;
        m_tready    = 1'b1;
        s_crc_valid = 1'b1;
        m_crc_ready = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst pre busy", 64'(m_tvalid), 64'd1);
        check("rst pre grant", 64'(grant_id), 64'd2);
        check("rst pre crc route", 64'(m_crc_valid), 64'(4'b0100));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst tready", 64'(s_tready), 64'd0);
        check("rst m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst grant_id", 64'(grant_id), 64'd0);
        check("rst m_crc_valid", 64'(m_crc_valid), 64'd0);
        check("rst s_crc_ready", 64'(s_crc_ready), 64'd0);
        check("rst orphan_err", 64'(orphan_err), 64'd0);
        s_crc_valid = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        s_tvalid = 4'b1010;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst restart grant", 64'(grant_id), 64'd1);
        check("rst restart tready", 64'(s_tready), 64'(4'b0010));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
